// File: rtl/dcache_stage.sv
// Direct-mapped write-back/write-allocate data cache stage (4 x 128-bit lines).
// Define DCACHE_BYPASS_EN to forward WB register-file data back to the ALU stage.

package dcache_pkg;
  parameter int unsigned PcWidth      = 32;
  parameter int unsigned RegAddrWidth = 5;

  typedef enum logic {
    SizeByte = 1'b0,
    SizeWord = 1'b1
  } dcache_size_e;

  typedef struct packed {
    logic [31:0]  addr;
    dcache_size_e size;
    logic         is_store;
    logic [31:0]  data;
  } dcache_request_t;
endpackage

module dcache_stage
  import dcache_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_dcache_valid,
  input  dcache_request_t         req_dcache_info,
  input  logic [PcWidth-1:0]      req_dcache_pc,
  input  logic                    req_m_type_instr,
  input  logic                    req_r_type_instr,
  input  logic [RegAddrWidth-1:0] req_dst_reg,
  output logic                    dcache_busy,
  output logic                    req_wb_valid,
  output logic [PcWidth-1:0]      req_wb_pc,
  output logic                    req_wb_rf_write,
  output logic [RegAddrWidth-1:0] req_wb_dst_reg,
  output logic [31:0]             req_wb_data,
  output logic                    mem_req_valid,
  output logic                    mem_req_is_store,
  output logic [31:0]             mem_req_addr,
  output logic [127:0]            mem_req_data,
  input  logic                    mem_rsp_valid,
  input  logic [127:0]            mem_rsp_data,
  output logic [31:0]             cache_data_bypass,
  output logic                    cache_data_bp_valid
);

  typedef enum logic [1:0] {
    StIdle,
    StEvict,
    StFill,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [127:0] line_q [4];
  logic [25:0]  tag_q  [4];
  logic [3:0]   valid_q, dirty_q;

  dcache_request_t         cap_info_q, cap_info_d;
  logic [PcWidth-1:0]      cap_pc_q, cap_pc_d;
  logic [RegAddrWidth-1:0] cap_dst_q, cap_dst_d;

  logic                    wb_valid_q, wb_valid_d;
  logic [PcWidth-1:0]      wb_pc_q, wb_pc_d;
  logic                    wb_rf_write_q, wb_rf_write_d;
  logic [RegAddrWidth-1:0] wb_dst_q, wb_dst_d;
  logic [31:0]             wb_data_q, wb_data_d;

  // RESP replays the captured request through the same hit path used in IDLE.
  dcache_request_t         acc_info;
  logic [PcWidth-1:0]      acc_pc;
  logic [RegAddrWidth-1:0] acc_dst;
  logic [1:0]              acc_idx, cap_idx;
  logic [127:0]            acc_line, store_line;
  logic                    acc_hit;
  logic [31:0]             load_data;
  logic                    do_access, store_we, fill_we, busy;

  assign acc_info = (state_q == StResp) ? cap_info_q : req_dcache_info;
  assign acc_pc   = (state_q == StResp) ? cap_pc_q : req_dcache_pc;
  assign acc_dst  = (state_q == StResp) ? cap_dst_q : req_dst_reg;
  assign acc_idx  = acc_info.addr[5:4];
  assign cap_idx  = cap_info_q.addr[5:4];
  assign acc_line = line_q[acc_idx];
  assign acc_hit  = valid_q[acc_idx] && (tag_q[acc_idx] == acc_info.addr[31:6]);

  always_comb begin
    store_line = acc_line;
    if (acc_info.size == SizeWord) begin
      store_line[{acc_info.addr[3:2], 5'd0} +: 32] = acc_info.data;
      load_data = acc_line[{acc_info.addr[3:2], 5'd0} +: 32];
    end else begin
      store_line[{acc_info.addr[3:0], 3'd0} +: 8] = acc_info.data[7:0];
      load_data = {24'h0, acc_line[{acc_info.addr[3:0], 3'd0} +: 8]};
    end
  end

  always_comb begin
    state_d       = state_q;
    cap_info_d    = cap_info_q;
    cap_pc_d      = cap_pc_q;
    cap_dst_d     = cap_dst_q;
    wb_valid_d    = 1'b0;
    wb_pc_d       = '0;
    wb_rf_write_d = 1'b0;
    wb_dst_d      = '0;
    wb_data_d     = '0;
    do_access     = 1'b0;
    fill_we       = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_dcache_valid) begin
          if (!req_m_type_instr) begin
            wb_valid_d    = 1'b1;
            wb_pc_d       = req_dcache_pc;
            wb_rf_write_d = req_r_type_instr;
            wb_dst_d      = req_dst_reg;
            wb_data_d     = req_dcache_info.data;
          end else if (acc_hit) begin
            do_access = 1'b1;
          end else begin
            busy       = 1'b1;
            cap_info_d = req_dcache_info;
            cap_pc_d   = req_dcache_pc;
            cap_dst_d  = req_dst_reg;
            state_d    = (valid_q[acc_idx] && dirty_q[acc_idx]) ? StEvict : StFill;
          end
        end
      end
      StEvict: begin
        busy = 1'b1;
        if (mem_rsp_valid) state_d = StFill;
      end
      StFill: begin
        busy = 1'b1;
        if (mem_rsp_valid) begin
          fill_we = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        busy      = 1'b1;
        do_access = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (do_access) begin
      wb_valid_d    = 1'b1;
      wb_pc_d       = acc_pc;
      wb_dst_d      = acc_dst;
      wb_rf_write_d = !acc_info.is_store;
      wb_data_d     = acc_info.is_store ? acc_info.data : load_data;
    end
  end

  assign store_we    = do_access && acc_info.is_store;
  assign dcache_busy = busy && reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cap_info_q    <= '0;
      cap_pc_q      <= '0;
      cap_dst_q     <= '0;
      wb_valid_q    <= 1'b0;
      wb_pc_q       <= '0;
      wb_rf_write_q <= 1'b0;
      wb_dst_q      <= '0;
      wb_data_q     <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        line_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      cap_info_q    <= cap_info_d;
      cap_pc_q      <= cap_pc_d;
      cap_dst_q     <= cap_dst_d;
      wb_valid_q    <= wb_valid_d;
      wb_pc_q       <= wb_pc_d;
      wb_rf_write_q <= wb_rf_write_d;
      wb_dst_q      <= wb_dst_d;
      wb_data_q     <= wb_data_d;
      if (fill_we) begin
        line_q[cap_idx]  <= mem_rsp_data;
        tag_q[cap_idx]   <= cap_info_q.addr[31:6];
        valid_q[cap_idx] <= 1'b1;
        dirty_q[cap_idx] <= 1'b0;
      end
      if (store_we) begin
        line_q[acc_idx]  <= store_line;
        dirty_q[acc_idx] <= 1'b1;
      end
    end
  end

  assign req_wb_valid    = wb_valid_q;
  assign req_wb_pc       = wb_pc_q;
  assign req_wb_rf_write = wb_rf_write_q;
  assign req_wb_dst_reg  = wb_dst_q;
  assign req_wb_data     = wb_data_q;

  always_comb begin
    mem_req_valid    = (state_q == StEvict) || (state_q == StFill);
    mem_req_is_store = (state_q == StEvict);
    mem_req_addr     = '0;
    mem_req_data     = '0;
    if (state_q == StEvict) begin
      mem_req_addr = {tag_q[cap_idx], cap_idx, 4'b0};
      mem_req_data = line_q[cap_idx];
    end else if (state_q == StFill) begin
      mem_req_addr = {cap_info_q.addr[31:4], 4'b0};
    end
  end

`ifdef DCACHE_BYPASS_EN
  assign cache_data_bypass   = wb_data_q;
  assign cache_data_bp_valid = wb_valid_q & wb_rf_write_q;
`else
  assign cache_data_bypass   = '0;
  assign cache_data_bp_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_stage.sv
// Scoreboard bench for dcache_stage: reference cache/memory model predicts WB and memory traffic.

module tb_dcache_stage;
  import dcache_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    req_dcache_valid;
  dcache_request_t         req_dcache_info;
  logic [PcWidth-1:0]      req_dcache_pc;
  logic                    req_m_type_instr;
  logic                    req_r_type_instr;
  logic [RegAddrWidth-1:0] req_dst_reg;
  logic                    dcache_busy;
  logic                    req_wb_valid;
  logic [PcWidth-1:0]      req_wb_pc;
  logic                    req_wb_rf_write;
  logic [RegAddrWidth-1:0] req_wb_dst_reg;
  logic [31:0]             req_wb_data;
  logic                    mem_req_valid;
  logic                    mem_req_is_store;
  logic [31:0]             mem_req_addr;
  logic [127:0]            mem_req_data;
  logic                    mem_rsp_valid;
  logic [127:0]            mem_rsp_data;
  logic [31:0]             cache_data_bypass;
  logic                    cache_data_bp_valid;

  dcache_stage u_dut (
    .clock              (clock),
    .reset              (reset),
    .req_dcache_valid   (req_dcache_valid),
    .req_dcache_info    (req_dcache_info),
    .req_dcache_pc      (req_dcache_pc),
    .req_m_type_instr   (req_m_type_instr),
    .req_r_type_instr   (req_r_type_instr),
    .req_dst_reg        (req_dst_reg),
    .dcache_busy        (dcache_busy),
    .req_wb_valid       (req_wb_valid),
    .req_wb_pc          (req_wb_pc),
    .req_wb_rf_write    (req_wb_rf_write),
    .req_wb_dst_reg     (req_wb_dst_reg),
    .req_wb_data        (req_wb_data),
    .mem_req_valid      (mem_req_valid),
    .mem_req_is_store   (mem_req_is_store),
    .mem_req_addr       (mem_req_addr),
    .mem_req_data       (mem_req_data),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_data       (mem_rsp_data),
    .cache_data_bypass  (cache_data_bypass),
    .cache_data_bp_valid(cache_data_bp_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        rf;
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t mon_e;
  int      n_checks = 0;
  int      n_errors = 0;

  logic [127:0] m_line [4];
  logic [25:0]  m_tag  [4];
  bit           m_valid[4];
  bit           m_dirty[4];
  logic [127:0] mem_q [logic [31:0]];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (mem_q.exists(a)) return mem_q[a];
    return {a ^ 32'hC0DE_0003, a ^ 32'hC0DE_0002, a ^ 32'hC0DE_0001, a ^ 32'hC0DE_0000};
  endfunction

  task automatic set_idle_inputs();
    req_dcache_valid = 1'b0;
    req_dcache_info  = '0;
    req_dcache_pc    = '0;
    req_m_type_instr = 1'b0;
    req_r_type_instr = 1'b0;
    req_dst_reg      = '0;
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Wait for a memory request, check it, hold one extra cycle, then acknowledge.
  task automatic wait_mem(input bit st, input logic [31:0] addr, input logic [127:0] data,
                          input logic [127:0] rsp);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!mem_req_valid && n < 20);
    check_val("mem_req_valid", mem_req_valid, 1);
    check_val("mem_req_is_store", mem_req_is_store, st);
    check_val("mem_req_addr", mem_req_addr, addr);
    if (st) check_val("mem_req_data", mem_req_data, data);
    check_val("busy_mem", dcache_busy, 1);
    @(negedge clock);
    check_val("mem_req_hold", mem_req_valid, 1);
    @(posedge clock);
    #1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rsp;
    @(posedge clock);
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  task automatic mem_access(input logic [31:0] addr, input bit word, input bit store,
                            input logic [31:0] data, input logic [4:0] dst,
                            input logic [31:0] pc);
    logic [1:0]   idx;
    logic [25:0]  tag;
    bit           hit, ev;
    logic [31:0]  ev_addr, fill_addr;
    logic [127:0] ev_data, fill_data, line;
    wb_exp_t      e;
    idx       = addr[5:4];
    tag       = addr[31:6];
    hit       = m_valid[idx] && (m_tag[idx] == tag);
    ev        = !hit && m_valid[idx] && m_dirty[idx];
    ev_addr   = {m_tag[idx], idx, 4'h0};
    ev_data   = m_line[idx];
    fill_addr = {addr[31:4], 4'h0};
    if (ev) mem_q[ev_addr] = ev_data;
    fill_data = mem_line(fill_addr);
    if (!hit) begin
      m_line[idx]  = fill_data;
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    line = m_line[idx];
    if (store) begin
      if (word) line[addr[3:2]*32 +: 32] = data;
      else      line[addr[3:0]*8 +: 8]   = data[7:0];
      m_line[idx]  = line;
      m_dirty[idx] = 1'b1;
      e.rf   = 1'b0;
      e.data = data;
    end else begin
      e.rf   = 1'b1;
      e.data = word ? line[addr[3:2]*32 +: 32] : {24'h0, line[addr[3:0]*8 +: 8]};
    end
    e.pc  = pc;
    e.dst = dst;
    exp_q.push_back(e);

    @(posedge clock);
    #1;
    req_dcache_valid = 1'b1;
    req_m_type_instr = 1'b1;
    req_r_type_instr = 1'b0;
    req_dcache_info  = '{addr: addr, size: (word ? SizeWord : SizeByte), is_store: store,
                         data: data};
    req_dcache_pc    = pc;
    req_dst_reg      = dst;
    @(negedge clock);
    check_val("busy_detect", dcache_busy, !hit);
    @(posedge clock);
    #1;
    if (hit) begin
      set_idle_inputs();
      @(negedge clock);
      check_val("hit_latency", req_wb_valid, 1);
      check_val("hit_busy", dcache_busy, 0);
    end else begin
      // Junk request held while busy must never produce a WB.
      req_m_type_instr = 1'b0;
      req_r_type_instr = 1'b1;
      req_dcache_info  = '{addr: 32'h0, size: SizeWord, is_store: 1'b0, data: 32'hBAD0_0BAD};
      req_dst_reg      = 5'd31;
      req_dcache_pc    = 32'hFFFF_0000;
      if (ev) wait_mem(1'b1, ev_addr, ev_data, '0);
      wait_mem(1'b0, fill_addr, '0, fill_data);
      set_idle_inputs();
      check_val("busy_resp", dcache_busy, 1);
      @(posedge clock);
      @(negedge clock);
      check_val("miss_wb_valid", req_wb_valid, 1);
      check_val("miss_busy_drop", dcache_busy, 0);
    end
  endtask

  task automatic nonmem(input bit r_type, input logic [31:0] data, input logic [4:0] dst,
                        input logic [31:0] pc);
    wb_exp_t e;
    e.pc   = pc;
    e.rf   = r_type;
    e.dst  = dst;
    e.data = data;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    req_dcache_valid = 1'b1;
    req_m_type_instr = 1'b0;
    req_r_type_instr = r_type;
    req_dcache_info  = '{addr: 32'h0, size: SizeWord, is_store: 1'b0, data: data};
    req_dcache_pc    = pc;
    req_dst_reg      = dst;
    @(negedge clock);
    check_val("nonmem_busy", dcache_busy, 0);
    @(posedge clock);
    #1;
    set_idle_inputs();
    @(negedge clock);
    check_val("nonmem_wb_valid", req_wb_valid, 1);
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && req_wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("wb_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wb_pc", req_wb_pc, mon_e.pc);
        check_val("wb_dst", req_wb_dst_reg, mon_e.dst);
        check_val("wb_rf_write", req_wb_rf_write, mon_e.rf);
        if (mon_e.rf) check_val("wb_data", req_wb_data, mon_e.data);
`ifdef DCACHE_BYPASS_EN
        check_val("bp_valid", cache_data_bp_valid, mon_e.rf);
        if (mon_e.rf) check_val("bp_data", cache_data_bypass, mon_e.data);
`else
        check_val("bp_valid", cache_data_bp_valid, 0);
        check_val("bp_data", cache_data_bypass, 0);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle_inputs();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    reset         = 1'b0;
    model_invalidate();
    repeat (2) @(negedge clock);
    check_val("rst_wb_valid", req_wb_valid, 0);
    check_val("rst_busy", dcache_busy, 0);
    check_val("rst_mem_req_valid", mem_req_valid, 0);
    check_val("rst_mem_req_addr", mem_req_addr, 0);
    check_val("rst_wb_data", req_wb_data, 0);
    check_val("rst_bp_valid", cache_data_bp_valid, 0);
    reset = 1'b1;

    nonmem(1'b1, 32'h0000_1234, 5'd5, 32'h0000_0010);
    nonmem(1'b0, 32'h0000_5678, 5'd7, 32'h0000_0014);

    mem_q[32'h100] = 128'h44443333_22221111_00000000_AAAAAAAA;
    mem_access(32'h104, 1'b1, 1'b0, 32'h0, 5'd1, 32'h20);            // cold LDW
    mem_access(32'h107, 1'b0, 1'b1, 32'h0000_00A5, 5'd2, 32'h24);    // STB hit
    mem_access(32'h107, 1'b0, 1'b0, 32'h0, 5'd3, 32'h28);            // LDB -> A5
    mem_access(32'h108, 1'b1, 1'b0, 32'h0, 5'd4, 32'h2C);
    mem_access(32'h10C, 1'b0, 1'b0, 32'h0, 5'd6, 32'h30);
    mem_access(32'h10F, 1'b1, 1'b0, 32'h0, 5'd8, 32'h34);            // addr[1:0] ignored

    mem_access(32'h000, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd9, 32'h40);    // evicts 0x100
    mem_access(32'h040, 1'b1, 1'b0, 32'h0, 5'd10, 32'h44);           // evicts 0x000
    mem_access(32'h000, 1'b1, 1'b0, 32'h0, 5'd11, 32'h48);           // reads back DEADBEEF
    mem_access(32'h107, 1'b0, 1'b0, 32'h0, 5'd12, 32'h4C);           // reads back A5

    mem_access(32'h1230, 1'b1, 1'b1, 32'hCAFE_F00D, 5'd13, 32'h50);
    @(posedge clock);
    #1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {4{32'hFFFF_FFFF}};
    @(posedge clock);
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    @(negedge clock);
    check_val("idle_rsp_mem_req", mem_req_valid, 0);
    check_val("idle_rsp_busy", dcache_busy, 0);
    check_val("idle_rsp_wb", req_wb_valid, 0);
    mem_access(32'h1230, 1'b1, 1'b0, 32'h0, 5'd14, 32'h54);

    // Abort a fill with reset; dirty 0x1230 data is lost.
    @(posedge clock);
    #1;
    req_dcache_valid = 1'b1;
    req_m_type_instr = 1'b1;
    req_dcache_info  = '{addr: 32'h200, size: SizeWord, is_store: 1'b0, data: 32'h0};
    req_dcache_pc    = 32'h58;
    req_dst_reg      = 5'd15;
    @(negedge clock);
    check_val("abort_busy", dcache_busy, 1);
    @(posedge clock);
    #1;
    set_idle_inputs();
    @(negedge clock);
    check_val("abort_fill_valid", mem_req_valid, 1);
    check_val("abort_fill_addr", mem_req_addr, 32'h200);
    #2;
    reset = 1'b0;
    #1;
    check_val("abort_rst_busy", dcache_busy, 0);
    check_val("abort_rst_mem_req", mem_req_valid, 0);
    check_val("abort_rst_mem_addr", mem_req_addr, 0);
    check_val("abort_rst_wb", req_wb_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    model_invalidate();

    mem_access(32'h1230, 1'b1, 1'b0, 32'h0, 5'd16, 32'h60);          // must miss again
    mem_access(32'h200, 1'b1, 1'b0, 32'h0, 5'd17, 32'h64);

    repeat (3) @(negedge clock);
    check_val("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_stage.md
DCACHE_STAGE -- requirements
Module: dcache_stage

Interface
REQ-001 SHALL have exactly one clock (`clock`); reset port `reset` is asynchronous, active-low (asserted at 0).
REQ-002 Ports, in order:
- `clock` in 1: rising-edge clock.
- `reset` in 1: async active-low reset.
- `req_dcache_valid` in 1: request from ALU stage.
- `req_dcache_info` in dcache_request_t: addr[31:0], size (Byte/Word), is_store, data[31:0].
- `req_dcache_pc` in PC_WIDTH: request PC.
- `req_m_type_instr` in 1: request accesses memory.
- `req_r_type_instr` in 1: request writes the register file from info.data.
- `req_dst_reg` in REG_FILE_ADDR_RANGE: destination register.
- `dcache_busy` out 1: stall to ALU stage (drives stall_alu).
- `req_wb_valid` out 1: request to WB stage.
- `req_wb_pc` out PC_WIDTH: PC to WB.
- `req_wb_rf_write` out 1: WB writes RF.
- `req_wb_dst_reg` out REG_FILE_ADDR_RANGE: WB destination register.
- `req_wb_data` out 32: WB write data.
- `mem_req_valid` out 1: memory request, level.
- `mem_req_is_store` out 1: 1 = line write-back, 0 = line fill.
- `mem_req_addr` out 32: line address, bits [3:0] = 0.
- `mem_req_data` out 128: victim line.
- `mem_rsp_valid` in 1: memory ack / fill data valid, 1-cycle pulse.
- `mem_rsp_data` in 128: fill line.
- `cache_data_bypass` out 32: bypass data to ALU stage.
- `cache_data_bp_valid` out 1: bypass valid.

Function
REQ-003 Storage SHALL be direct-mapped, write-back, write-allocate: 4 lines x 128 bits; index = addr[5:4], tag = addr[31:6], with a valid bit and a dirty bit per line.
REQ-004 FSM states SHALL be IDLE, EVICT, FILL, RESP.
REQ-005 In IDLE, a `req_dcache_valid` request with `req_m_type_instr`=0 SHALL produce `req_wb_valid`=1 on the next cycle:
- data = info.data;
- rf_write = `req_r_type_instr`;
- pc and dst_reg are passed through.
REQ-006 An IDLE memory request that hits SHALL complete with 1-cycle latency: WB outputs are valid the next cycle and `dcache_busy` stays 0.
REQ-007 Load data rules:
- Word load returns the word at addr[3:2]; addr[1:0] are ignored.
- Byte load returns the byte at addr[3:0], zero-extended to 32 bits.
- rf_write = 1.
REQ-008 Store rules:
- Word store writes info.data into word addr[3:2]; byte store writes info.data[7:0] into byte addr[3:0].
- The line's dirty bit is set.
- `req_wb_valid`=1 with rf_write = 0.
REQ-009 An IDLE memory miss SHALL capture the request, assert `dcache_busy` combinationally in the same cycle, and move to EVICT if the victim is valid and dirty, otherwise to FILL.
REQ-010 EVICT SHALL drive `mem_req_valid`=1 with is_store = 1, addr = {victim tag, index, 4'b0} and data = victim line, holding them until `mem_rsp_valid`, then go to FILL.
REQ-011 FILL SHALL drive `mem_req_valid`=1 with is_store = 0 and addr = {req addr[31:4], 4'b0} until `mem_rsp_valid`. It then writes `mem_rsp_data`, sets valid=1, dirty=0, updates the tag, and goes to RESP.
REQ-012 RESP SHALL perform the captured access as a hit, drive WB outputs the next cycle, deassert `dcache_busy`, and return to IDLE.
REQ-013 `dcache_busy` SHALL be 1 from the miss-detect cycle through the cycle before RESP exits.
REQ-014 `req_dcache_valid` SHALL be ignored whenever `dcache_busy`=1. The first valid request after `dcache_busy` falls is a new request; the captured request is never re-executed.
REQ-015 `mem_rsp_valid` SHALL be ignored in IDLE and RESP. `mem_req_valid`=0 outside EVICT/FILL.
REQ-016 `req_wb_valid` SHALL be 0 in every cycle with no completing request.

Reset
REQ-017 While `reset`=0, all outputs SHALL be 0, the state SHALL be IDLE, and all valid and dirty bits SHALL be cleared.
REQ-018 Reset asserted mid-EVICT/FILL SHALL abort the access; dirty data is lost and no WB is produced.

Configuration
REQ-019 With macro DCACHE_BYPASS_EN defined:
- `cache_data_bypass` = `req_wb_data`;
- `cache_data_bp_valid` = `req_wb_valid` & `req_wb_rf_write`.
REQ-020 Without DCACHE_BYPASS_EN, both bypass outputs SHALL be tied to 0.

Verification
REQ-021 Cold LDW addr 0x00000104 with memory returning line 0x44443333_22221111_00000000_AAAAAAAA -> FILL at 0x00000100, `dcache_busy` high until RESP, then WB data 0x00000000, rf_write = 1.
REQ-022 STB 0xA5 to 0x00000107 (hit), then LDB 0x00000107 -> WB 0x000000A5 with 1-cycle latency, `dcache_busy`=0 throughout.
REQ-023 Dirty line at index 0 with tag of 0x00000000, then LDW 0x00000040 -> EVICT writes to addr 0x00000000, after ack FILL at 0x00000040, then WB.
REQ-024 Non-memory request (r_type = 1, data 0x1234, dst 5) -> next cycle `req_wb_valid`=1, data 0x1234, dst 5; bypass valid only with DCACHE_BYPASS_EN.
REQ-025 Reset pulse during FILL -> outputs 0, state IDLE; the next access to the same address misses.
REQ-026 `req_dcache_valid` asserted while busy -> no extra WB; memory `mem_rsp_valid` pulse in IDLE -> ignored.
